axi_info_probe: RTL and testbench
=================================

AXI_INFO_PROBE -- requirements
Module: axi_info_probe

Interface
REQ-001 Parameter N, default 6: number of 32-bit words read per scan, 1..16.
REQ-002 Parameter ADDR_BITS, default 5: AXI-Lite address width.
REQ-003 Parameter BASE, default 0: byte address of word 0, 4-byte aligned.
REQ-004 Parameter MAGIC, default 32'h4649_4E4E: expected value of word 0.
REQ-005 Parameter TIMEOUT, default 1024: maximum wait cycles per channel phase (used only under REQ-027).
REQ-006 Port ap_clk  in  1  sole clock; all logic on rising edge.
REQ-007 Port ap_rst_n  in  1  reset; synchronous and active-low.
REQ-008 Ports start in 1 (scan request pulse); busy out 1; done out 1 (one-cycle pulse); err out 1 (sticky); sig_ok out 1.
REQ-009 Ports m_axi_ARVALID out 1, m_axi_ARREADY in 1, m_axi_ARADDR out ADDR_BITS: read address channel.
REQ-010 Ports m_axi_RVALID in 1, m_axi_RREADY out 1, m_axi_RDATA in 32, m_axi_RRESP in 2: read data channel.
REQ-011 Ports m_axi_AWVALID/WVALID/BREADY out 1, AWADDR out ADDR_BITS, WDATA out 32, WSTRB out 4, AWREADY/WREADY/BVALID in 1, BRESP in 2: write channels.
REQ-012 Ports dat_TVALID out 1, dat_TREADY in 1, dat_TDATA out 32, dat_TLAST out 1: word output stream.

Function
REQ-013 Write channels SHALL be tied off: AWVALID=WVALID=0, BREADY=1, AWADDR/WDATA/WSTRB=0.
REQ-014 FSM states SHALL be IDLE, AR, R, EMIT; busy=1 in every state except IDLE.
REQ-015 IDLE: start=1 SHALL clear err and sig_ok, set index i=0, go to AR next cycle; start ignored outside IDLE.
REQ-016 AR: ARVALID=1, ARADDR=(BASE+4*i) mod 2^ADDR_BITS held stable; on ARVALID&&ARREADY go to R.
REQ-017 R: RREADY=1; on RVALID capture RDATA into output register, go to EMIT; at most one read outstanding.
REQ-018 RRESP!=2'b00 SHALL set err; the captured word is still emitted.
REQ-019 EMIT: dat_TVALID=1, TDATA stable until dat_TVALID&&dat_TREADY; TLAST=1 iff i==N-1.
REQ-020 On EMIT handshake: if i<N-1 then i++ and go to AR; else pulse done for one cycle and go to IDLE.
REQ-021 sig_ok SHALL be set when word 0 is captured with value MAGIC and RRESP==OKAY; held until next start.
REQ-022 Minimum scan latency: start to done = 3N+1 cycles with ARREADY, RVALID, TREADY asserted on first opportunity.
REQ-023 i SHALL be $clog2(N+1) bits wide; address arithmetic truncates to ADDR_BITS (wrap-around legal).

Reset
REQ-024 ap_rst_n=0 at a rising edge SHALL force IDLE, i=0, and busy, done, err, sig_ok, ARVALID, RREADY, dat_TVALID, TDATA, TLAST all 0.
REQ-025 Reset mid-scan SHALL abandon the transaction with no done pulse; the slave is assumed reset by the same signal.

Configuration
REQ-026 Macro AXI_INFO_PROBE_TIMEOUT_EN SHALL select a per-phase watchdog.
REQ-027 Defined: counter clears on entry to AR or R; if TIMEOUT cycles pass without the phase handshake, set err, drop ARVALID/RREADY, pulse done, go to IDLE; no stream output for aborted word.
REQ-028 Undefined: no counter, AR and R wait indefinitely; TIMEOUT unused.

Structure
REQ-029 Package axi_info_pkg SHALL hold the state enum, RESP_OKAY=2'b00, and MAGIC default 32'h4649_4E4E.
REQ-030 Single module, no sub-modules; the watchdog is an in-module counter.

Verification
REQ-031 Slave with words {4649_4E4E,1,2,3,0,5}, always ready -> stream 6 words in order, TLAST on 6th, done at cycle 19, sig_ok=1, err=0.
REQ-032 Slave returns word 0 = DEAD_BEEF -> sig_ok=0, err=0, all 6 words emitted.
REQ-033 RRESP=2'b10 on word 3 -> err=1 sticky, word still emitted, done pulses; next start clears err.
REQ-034 dat_TREADY low 5 cycles in EMIT, random ARREADY/RVALID stalls -> TDATA/ARADDR stable while stalled, no word lost or duplicated.
REQ-035 BASE=5'h18, N=4 -> ARADDR sequence 18,1C,00,04.
REQ-036 With AXI_INFO_PROBE_TIMEOUT_EN, TIMEOUT=16, RVALID never asserted -> err=1, done 16 cycles after AR handshake, FSM IDLE; reset asserted mid-scan -> all outputs 0 next cycle.

Source files
------------

// File: rtl/axi_info_probe_pkg.sv
// Shared types and constants for the AXI-Lite info-block probe.
package axi_info_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StR,
        StEmit
    } state_e;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [31:0] MAGIC_DEFAULT = 32'h4649_4E4E;

endpackage

// File: rtl/axi_info_probe_if.sv
// AXI-Lite master channels plus the word output stream of the info probe.
interface axi_info_probe_if #(
    parameter int unsigned ADDR_BITS = 5
);

    logic                 m_axi_ARVALID;
    logic                 m_axi_ARREADY;
    logic [ADDR_BITS-1:0] m_axi_ARADDR;
    logic                 m_axi_RVALID;
    logic                 m_axi_RREADY;
    logic [31:0]          m_axi_RDATA;
    logic [1:0]           m_axi_RRESP;
    logic                 m_axi_AWVALID;
    logic                 m_axi_AWREADY;
    logic [ADDR_BITS-1:0] m_axi_AWADDR;
    logic                 m_axi_WVALID;
    logic                 m_axi_WREADY;
    logic [31:0]          m_axi_WDATA;
    logic [3:0]           m_axi_WSTRB;
    logic                 m_axi_BVALID;
    logic                 m_axi_BREADY;
    logic [1:0]           m_axi_BRESP;
    logic                 dat_TVALID;
    logic                 dat_TREADY;
    logic [31:0]          dat_TDATA;
    logic                 dat_TLAST;

    modport master (
        output m_axi_ARVALID, m_axi_ARADDR, m_axi_RREADY,
        output m_axi_AWVALID, m_axi_AWADDR, m_axi_WVALID, m_axi_WDATA, m_axi_WSTRB, m_axi_BREADY,
        output dat_TVALID, dat_TDATA, dat_TLAST,
        input  m_axi_ARREADY, m_axi_RVALID, m_axi_RDATA, m_axi_RRESP,
        input  m_axi_AWREADY, m_axi_WREADY, m_axi_BVALID, m_axi_BRESP,
        input  dat_TREADY
    );

    modport slave (
        input  m_axi_ARVALID, m_axi_ARADDR, m_axi_RREADY,
        input  m_axi_AWVALID, m_axi_AWADDR, m_axi_WVALID, m_axi_WDATA, m_axi_WSTRB, m_axi_BREADY,
        input  dat_TVALID, dat_TDATA, dat_TLAST,
        output m_axi_ARREADY, m_axi_RVALID, m_axi_RDATA, m_axi_RRESP,
        output m_axi_AWREADY, m_axi_WREADY, m_axi_BVALID, m_axi_BRESP,
        output dat_TREADY
    );

endinterface

// File: rtl/axi_info_probe.sv
// Reads N words from an AXI-Lite slave and streams them out, checking word 0 for MAGIC.
// Define AXI_INFO_PROBE_TIMEOUT_EN to add a per-phase watchdog on the AR and R phases.
module axi_info_probe
    import axi_info_pkg::*;
#(
    parameter int unsigned N         = 6,
    parameter int unsigned ADDR_BITS = 5,
    parameter logic [31:0] BASE      = 32'h0,
    parameter logic [31:0] MAGIC     = MAGIC_DEFAULT,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             sig_ok,
    axi_info_probe_if.master bus
);

    localparam int unsigned   IW       = $clog2(N + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tlast_q, tlast_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          sig_ok_q, sig_ok_d;
    logic [31:0]   addr_full;
    logic          ar_hs, r_hs, t_hs;

    // Byte address of the current word; truncation to ADDR_BITS gives legal wrap-around.
    assign addr_full = BASE + (32'(idx_q) << 2);

    assign ar_hs = (state_q == StAr) && bus.m_axi_ARREADY;
    assign r_hs  = (state_q == StR) && bus.m_axi_RVALID;
    assign t_hs  = (state_q == StEmit) && bus.dat_TREADY;

`ifdef AXI_INFO_PROBE_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        wd_expired;

    assign wd_expired = (wd_q == TIMEOUT - 1);
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        done_d   = 1'b0;
        err_d    = err_q;
        sig_ok_d = sig_ok_q;
`ifdef AXI_INFO_PROBE_TIMEOUT_EN
        wd_d     = wd_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d    = 1'b0;
                    sig_ok_d = 1'b0;
                    idx_d    = '0;
                    state_d  = StAr;
`ifdef AXI_INFO_PROBE_TIMEOUT_EN
                    wd_d     = '0;
`endif
                end
            end
            StAr: begin
                if (ar_hs) begin
                    state_d = StR;
`ifdef AXI_INFO_PROBE_TIMEOUT_EN
                    wd_d    = '0;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_d    = wd_q + 32'd1;
`endif
                end
            end
            StR: begin
                if (r_hs) begin
                    tdata_d = bus.m_axi_RDATA;
                    tlast_d = (idx_q == LAST_IDX);
                    if (bus.m_axi_RRESP != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == '0 && bus.m_axi_RDATA == MAGIC && bus.m_axi_RRESP == RESP_OKAY) begin
                        sig_ok_d = 1'b1;
                    end
                    state_d = StEmit;
`ifdef AXI_INFO_PROBE_TIMEOUT_EN
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_d    = wd_q + 32'd1;
`endif
                end
            end
            StEmit: begin
                if (t_hs) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StAr;
`ifdef AXI_INFO_PROBE_TIMEOUT_EN
                        wd_d    = '0;
`endif
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sig_ok_q <= 1'b0;
`ifdef AXI_INFO_PROBE_TIMEOUT_EN
            wd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sig_ok_q <= sig_ok_d;
`ifdef AXI_INFO_PROBE_TIMEOUT_EN
            wd_q     <= wd_d;
`endif
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign err    = err_q;
    assign sig_ok = sig_ok_q;

    assign bus.m_axi_ARVALID = (state_q == StAr);
    assign bus.m_axi_ARADDR  = addr_full[ADDR_BITS-1:0];
    assign bus.m_axi_RREADY  = (state_q == StR);
    assign bus.dat_TVALID    = (state_q == StEmit);
    assign bus.dat_TDATA     = tdata_q;
    assign bus.dat_TLAST     = tlast_q;

    // Read-only master: write channels are permanently idle.
    assign bus.m_axi_AWVALID = 1'b0;
    assign bus.m_axi_AWADDR  = '0;
    assign bus.m_axi_WVALID  = 1'b0;
    assign bus.m_axi_WDATA   = '0;
    assign bus.m_axi_WSTRB   = '0;
    assign bus.m_axi_BREADY  = 1'b1;

    logic unused_in;
`ifdef AXI_INFO_PROBE_TIMEOUT_EN
    assign unused_in = ^{bus.m_axi_AWREADY, bus.m_axi_WREADY, bus.m_axi_BVALID, bus.m_axi_BRESP,
                         addr_full[31:ADDR_BITS]};
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign unused_in = ^{bus.m_axi_AWREADY, bus.m_axi_WREADY, bus.m_axi_BVALID, bus.m_axi_BRESP,
                         addr_full[31:ADDR_BITS], unused_timeout};
`endif

endmodule

// File: tb/tb_axi_info_probe.sv
// Scoreboard bench for axi_info_probe: randomized slave stalls, word-level reference model.
module tb_axi_info_probe;
    import axi_info_pkg::*;

    localparam int unsigned N0 = 6;
    localparam int unsigned N1 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, busy0, done0, err0, sig_ok0;
    logic start1 = 1'b0, busy1, done1, err1, sig_ok1;
    int   cyc = 0;
    int   ar_cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_data[$];
    logic        exp_last[$];
    logic [4:0]  exp_addr[$];
    logic [4:0]  exp_addr1[$];

    logic [31:0] mem[8];
    int ar_pct = 100, r_pct = 100, t_pct = 100;
    int bad_idx = -1;
    bit stall5 = 1'b0;
    bit rv_never = 1'b0;

    axi_info_probe_if #(.ADDR_BITS(5)) bus0 ();
    axi_info_probe_if #(.ADDR_BITS(5)) bus1 ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_info_probe #(
        .N(N0), .ADDR_BITS(5), .BASE(32'h0), .MAGIC(MAGIC_DEFAULT), .TIMEOUT(16)
    ) dut0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .err(err0), .sig_ok(sig_ok0), .bus(bus0)
    );

    axi_info_probe #(
        .N(N1), .ADDR_BITS(5), .BASE(32'h18), .MAGIC(MAGIC_DEFAULT), .TIMEOUT(16)
    ) dut1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .err(err1), .sig_ok(sig_ok1), .bus(bus1)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Memory-backed slave for dut0 with random ready/valid stalls.
    initial begin : slave0
        bit hs_ar, hs_r, pend, tv_last;
        logic [4:0] paddr, ar_a;
        int hold;
        pend = 0; tv_last = 0; hold = 0; hs_ar = 0; hs_r = 0; paddr = '0; ar_a = '0;
        bus0.m_axi_ARREADY = 0; bus0.m_axi_RVALID = 0; bus0.m_axi_RDATA = '0;
        bus0.m_axi_RRESP = '0; bus0.dat_TREADY = 0; bus0.m_axi_AWREADY = 0;
        bus0.m_axi_WREADY = 0; bus0.m_axi_BVALID = 0; bus0.m_axi_BRESP = '0;
        forever begin
            @(negedge clk);
            hs_ar = bus0.m_axi_ARVALID && bus0.m_axi_ARREADY;
            hs_r  = bus0.m_axi_RVALID && bus0.m_axi_RREADY;
            ar_a  = bus0.m_axi_ARADDR;
            @(posedge clk); #1;
            if (!rst_n) begin
                pend = 0; hold = 0; tv_last = 0;
                bus0.m_axi_RVALID = 0; bus0.m_axi_ARREADY = 0; bus0.dat_TREADY = 0;
            end else begin
                if (hs_r) begin
                    bus0.m_axi_RVALID = 0;
                    pend = 0;
                end
                if (hs_ar) begin
                    pend = 1;
                    paddr = ar_a;
                end
                if (pend && !bus0.m_axi_RVALID && !rv_never && $urandom_range(99) < r_pct) begin
                    bus0.m_axi_RVALID = 1;
                    bus0.m_axi_RDATA  = mem[paddr[4:2]];
                    bus0.m_axi_RRESP  = (int'(paddr[4:2]) == bad_idx) ? 2'b10 : 2'b00;
                end
                bus0.m_axi_ARREADY = ($urandom_range(99) < ar_pct);
                if (stall5 && bus0.dat_TVALID && !tv_last) hold = 5;
                tv_last = bus0.dat_TVALID;
                if (hold > 0) begin
                    bus0.dat_TREADY = 0;
                    hold--;
                end else begin
                    bus0.dat_TREADY = ($urandom_range(99) < t_pct);
                end
            end
        end
    end

    // Scoreboard monitor for dut0: stream words, AR addresses and stall stability.
    initial begin : mon0
        bit t_stall, a_stall;
        logic [31:0] t_prev;
        logic [4:0] a_prev;
        t_stall = 0; a_stall = 0; t_prev = '0; a_prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                t_stall = 0;
                a_stall = 0;
            end else begin
                if (t_stall) begin
                    check("tvalid_held", bus0.dat_TVALID, 1);
                    check("tdata_stable", bus0.dat_TDATA, t_prev);
                end
                if (a_stall) begin
                    check("arvalid_held", bus0.m_axi_ARVALID, 1);
                    check("araddr_stable", bus0.m_axi_ARADDR, a_prev);
                end
                if (bus0.dat_TVALID && bus0.dat_TREADY) begin
                    if (exp_data.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL stream_extra: got word %h with none expected", bus0.dat_TDATA);
                    end else begin
                        check("tdata", bus0.dat_TDATA, exp_data.pop_front());
                        check("tlast", bus0.dat_TLAST, exp_last.pop_front());
                    end
                end
                if (bus0.m_axi_ARVALID && bus0.m_axi_ARREADY) begin
                    ar_cyc = cyc + 1;
                    if (exp_addr.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL ar_extra: got addr %h with none expected", bus0.m_axi_ARADDR);
                    end else begin
                        check("araddr", bus0.m_axi_ARADDR, exp_addr.pop_front());
                    end
                end
                t_stall = bus0.dat_TVALID && !bus0.dat_TREADY;
                t_prev  = bus0.dat_TDATA;
                a_stall = bus0.m_axi_ARVALID && !bus0.m_axi_ARREADY;
                a_prev  = bus0.m_axi_ARADDR;
            end
        end
    end

    // dut1: always-ready slave, only the address sequence is checked.
    initial begin : slave1
        bus1.m_axi_ARREADY = 1; bus1.m_axi_RVALID = 1; bus1.m_axi_RDATA = 32'h0;
        bus1.m_axi_RRESP = 2'b00; bus1.dat_TREADY = 1; bus1.m_axi_AWREADY = 0;
        bus1.m_axi_WREADY = 0; bus1.m_axi_BVALID = 0; bus1.m_axi_BRESP = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus1.m_axi_ARVALID && bus1.m_axi_ARREADY) begin
                if (exp_addr1.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL n4_ar_extra: got addr %h with none expected", bus1.m_axi_ARADDR);
                end else begin
                    check("n4_araddr", bus1.m_axi_ARADDR, exp_addr1.pop_front());
                end
            end
        end
    end

    task automatic check_idle_outs(input string tag);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_err"}, err0, 0);
        check({tag, "_sig_ok"}, sig_ok0, 0);
        check({tag, "_arvalid"}, bus0.m_axi_ARVALID, 0);
        check({tag, "_rready"}, bus0.m_axi_RREADY, 0);
        check({tag, "_tvalid"}, bus0.dat_TVALID, 0);
        check({tag, "_tdata"}, bus0.dat_TDATA, 0);
        check({tag, "_tlast"}, bus0.dat_TLAST, 0);
    endtask

    task automatic run_scan0(input string tag, input bit chk_lat);
        int lat;
        bit exp_err, exp_sig;
        exp_err = 0;
        for (int i = 0; i < N0; i++) begin
            exp_data.push_back(mem[i]);
            exp_last.push_back(i == N0 - 1);
            exp_addr.push_back(5'(4 * i));
            if (i == bad_idx) exp_err = 1;
        end
        exp_sig = (mem[0] == MAGIC_DEFAULT) && (bad_idx != 0);
        @(posedge clk); #1 start0 = 1;
        @(posedge clk); #1 start0 = 0;
        check({tag, "_busy"}, busy0, 1);
        check({tag, "_err_cleared"}, err0, 0);
        check({tag, "_sig_cleared"}, sig_ok0, 0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done0 && lat < 3000);
        check({tag, "_done_seen"}, done0, 1);
        if (chk_lat) check({tag, "_latency"}, lat, 3 * N0 + 1);
        check({tag, "_err"}, err0, exp_err);
        check({tag, "_sig_ok"}, sig_ok0, exp_sig);
        check({tag, "_words_left"}, exp_data.size(), 0);
        check({tag, "_addrs_left"}, exp_addr.size(), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done0, 0);
        check({tag, "_idle"}, busy0, 0);
        check({tag, "_sig_held"}, sig_ok0, exp_sig);
    endtask

    task automatic fill_mem(input logic [31:0] w0);
        mem[0] = w0;
        for (int i = 1; i < 8; i++) mem[i] = $urandom;
    endtask

    initial begin : main
        int lat, seen;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outs("reset");
        check("reset_awvalid", bus0.m_axi_AWVALID, 0);
        check("reset_wvalid", bus0.m_axi_WVALID, 0);
        check("reset_bready", bus0.m_axi_BREADY, 1);
        rst_n = 1;

        // N=4 at BASE 0x18: addresses wrap through zero.
        exp_addr1 = '{5'h18, 5'h1C, 5'h00, 5'h04};
        @(posedge clk); #1 start1 = 1;
        @(posedge clk); #1 start1 = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done1 && lat < 200);
        check("n4_done_seen", done1, 1);
        check("n4_latency", lat, 3 * N1 + 1);
        check("n4_addrs_left", exp_addr1.size(), 0);

        mem = '{MAGIC_DEFAULT, 32'd1, 32'd2, 32'd3, 32'd0, 32'd5, 32'd0, 32'd0};
        run_scan0("basic", 1);

        fill_mem(32'hDEAD_BEEF);
        run_scan0("badmagic", 1);

        fill_mem(MAGIC_DEFAULT);
        bad_idx = 3; ar_pct = 60; r_pct = 60; t_pct = 70;
        run_scan0("rresp_err", 0);
        bad_idx = -1;
        fill_mem(MAGIC_DEFAULT);
        run_scan0("err_clear", 0);

        stall5 = 1;
        fill_mem(MAGIC_DEFAULT);
        run_scan0("stall5", 0);
        stall5 = 0;

        for (int k = 0; k < 4; k++) begin
            fill_mem(($urandom_range(1) == 1) ? MAGIC_DEFAULT : $urandom);
            bad_idx = int'($urandom_range(7)) - 1;
            ar_pct = 50 + int'($urandom_range(50));
            r_pct  = 50 + int'($urandom_range(50));
            t_pct  = 30 + int'($urandom_range(70));
            run_scan0("random", 0);
        end

        // Reset in the middle of a scan after err and sig_ok have been raised.
        ar_pct = 100; r_pct = 100; t_pct = 100; bad_idx = 1;
        fill_mem(MAGIC_DEFAULT);
        mem[2] = 32'hA5A5_0001;
        for (int i = 0; i < N0; i++) begin
            exp_data.push_back(mem[i]);
            exp_last.push_back(i == N0 - 1);
            exp_addr.push_back(5'(4 * i));
        end
        @(posedge clk); #1 start0 = 1;
        @(posedge clk); #1 start0 = 0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_err", err0, 1);
        check("pre_rst_sig_ok", sig_ok0, 1);
        check("pre_rst_busy", busy0, 1);
        rst_n = 0;
        @(posedge clk); #1;
        check_idle_outs("midrst");
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        @(posedge clk); #1 rst_n = 1;
        bad_idx = -1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0 || busy0) seen++;
        end
        check("midrst_no_done", seen, 0);

`ifdef AXI_INFO_PROBE_TIMEOUT_EN
        rv_never = 1;
        fill_mem(MAGIC_DEFAULT);
        exp_addr.push_back(5'h00);
        @(posedge clk); #1 start0 = 1;
        @(posedge clk); #1 start0 = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done0 && lat < 200);
        check("wd_done_seen", done0, 1);
        check("wd_delay", cyc - ar_cyc, 16);
        check("wd_err", err0, 1);
        check("wd_rready_dropped", bus0.m_axi_RREADY, 0);
        check("wd_addrs_left", exp_addr.size(), 0);
        @(negedge clk);
        check("wd_idle", busy0, 0);
        rv_never = 0;
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
